// File: rtl/mem_resp_pkg.sv
// Shared types and default address map for the memory responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  localparam logic [31:0] DEF_IMEM_LIMIT = 32'h0000_4000;
  localparam logic [31:0] DEF_DMEM_BASE  = 32'h0000_4000;
  localparam logic [31:0] DEF_DMEM_LIMIT = 32'h0001_0000;

endpackage

// File: rtl/mem_responder_addr_check.sv
// Combinational legality check for one requester's address and request kind.
module addr_check
  import mem_resp_pkg::*;
#(
  parameter int unsigned          ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]    IMEM_LIMIT = DEF_IMEM_LIMIT,
  parameter logic [ADDR_W-1:0]    DMEM_BASE  = DEF_DMEM_BASE,
  parameter logic [ADDR_W-1:0]    DMEM_LIMIT = DEF_DMEM_LIMIT
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              is_instr,
  input  logic              ld,
  input  logic              st,
  output logic              fault
);

  logic misaligned;
  logic instr_bad;
  logic data_bad;

  assign misaligned = (addr[1:0] != 2'b00);
  assign instr_bad  = (addr >= IMEM_LIMIT) | misaligned;
  // A simultaneous load and store has no defined meaning, so it faults.
  assign data_bad   = (addr < DMEM_BASE) | (addr >= DMEM_LIMIT) | misaligned | (ld & st);
  assign fault      = is_instr ? instr_bad : data_bad;

endmodule

// File: rtl/mem_responder.sv
// Arbitrates fetch and load/store requests onto one fixed-latency memory port.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       LATENCY    = 2,
  parameter logic [ADDR_W-1:0] IMEM_LIMIT = DEF_IMEM_LIMIT,
  parameter logic [ADDR_W-1:0] DMEM_BASE  = DEF_DMEM_BASE,
  parameter logic [ADDR_W-1:0] DMEM_LIMIT = DEF_DMEM_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_req,
  input  logic [ADDR_W-1:0] instr_addr,
  input  logic              ld,
  input  logic              st,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              wait_instr,
  output logic              wait_data,
  output logic              instr_segv,
  output logic              data_segv,
  output logic [DATA_W-1:0] instr_rdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              store_q, store_d;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              instr_segv_q, instr_segv_d;
  logic              data_segv_q, data_segv_d;
  logic [DATA_W-1:0] instr_rdata_q, instr_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

  logic instr_fault, data_fault;
  logic in_resp, instr_upd, data_upd;

  addr_check #(.ADDR_W(ADDR_W), .IMEM_LIMIT(IMEM_LIMIT), .DMEM_BASE(DMEM_BASE), .DMEM_LIMIT(DMEM_LIMIT))
    u_instr_chk (.addr(instr_addr), .is_instr(1'b1), .ld(1'b0), .st(1'b0), .fault(instr_fault));

  addr_check #(.ADDR_W(ADDR_W), .IMEM_LIMIT(IMEM_LIMIT), .DMEM_BASE(DMEM_BASE), .DMEM_LIMIT(DMEM_LIMIT))
    u_data_chk (.addr(data_addr), .is_instr(1'b0), .ld(ld), .st(st), .fault(data_fault));

  // Read data is only captured for a legal load/fetch whose requester is still waiting.
  assign in_resp   = (state_q == ST_RESP);
  assign instr_upd = in_resp & (owner_q == OWN_INSTR) & ~fault_q & instr_req;
  assign data_upd  = in_resp & (owner_q == OWN_DATA) & ~fault_q & ~store_q & ld;

  assign wait_instr  = instr_req & ~(in_resp & (owner_q == OWN_INSTR));
  assign wait_data   = (ld | st) & ~(in_resp & (owner_q == OWN_DATA));
  assign instr_segv  = instr_segv_q;
  assign data_segv   = data_segv_q;
  assign instr_rdata = instr_upd ? mem_rdata : instr_rdata_q;
  assign data_rdata  = data_upd ? mem_rdata : data_rdata_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

  // Next-state, arbitration and memory strobe generation.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    store_d       = store_q;
    fault_d       = fault_q;
    cnt_d         = cnt_q;
    mem_en_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    instr_segv_d  = 1'b0;
    data_segv_d   = 1'b0;
    instr_rdata_d = instr_rdata_q;
    data_rdata_d  = data_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (ld | st) begin
          owner_d = OWN_DATA;
          store_d = st;
          fault_d = data_fault;
          if (data_fault) begin
            state_d     = ST_RESP;
            data_segv_d = 1'b1;
          end else begin
            state_d     = ST_ACCESS;
            mem_en_d    = 1'b1;
            mem_we_d    = st;
            mem_addr_d  = {data_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = data_wdata;
            cnt_d       = CNT_W'(LATENCY - 1);
          end
        end else if (instr_req) begin
          owner_d = OWN_INSTR;
          store_d = 1'b0;
          fault_d = instr_fault;
          if (instr_fault) begin
            state_d      = ST_RESP;
            instr_segv_d = 1'b1;
          end else begin
            state_d    = ST_ACCESS;
            mem_en_d   = 1'b1;
            mem_addr_d = {instr_addr[ADDR_W-1:2], 2'b00};
            cnt_d      = CNT_W'(LATENCY - 1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (instr_upd) begin
          instr_rdata_d = mem_rdata;
        end else begin
          instr_rdata_d = instr_rdata_q;
        end
        if (data_upd) begin
          data_rdata_d = mem_rdata;
        end else begin
          data_rdata_d = data_rdata_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWN_INSTR;
      store_q       <= 1'b0;
      fault_q       <= 1'b0;
      cnt_q         <= '0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      instr_segv_q  <= 1'b0;
      data_segv_q   <= 1'b0;
      instr_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      store_q       <= store_d;
      fault_q       <= fault_d;
      cnt_q         <= cnt_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      instr_segv_q  <= instr_segv_d;
      data_segv_q   <= data_segv_d;
      instr_rdata_q <= instr_rdata_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

endmodule
